// File: rtl/tessia_cond_pkg.sv
// Shared types and constants for the TessiaV1 condition/flag logic.
package tessia_cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] nzcv_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of a 4-bit condition code against NZCV flags.
module cond_eval
  import tessia_cond_pkg::*;
(
  input  logic [3:0] cond,
  input  nzcv_t      flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      EQ: pass = z;
      NE: pass = !z;
      CS: pass = c;
      CC: pass = !c;
      MI: pass = n;
      PL: pass = !n;
      VS: pass = v;
      VC: pass = !v;
      HI: pass = c && !z;
      LS: pass = !c || z;
      GE: pass = (n == v);
      LT: pass = (n != v);
      GT: pass = !z && (n == v);
      LE: pass = z || (n != v);
      AL: pass = 1'b1;
      NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Flag consumer: NZCV register, in-flight flag-setter tracking, condition stall and evaluation.
module cond_flag_unit
  import tessia_cond_pkg::*;
#(
  parameter int MAX_PEND = 2,
  parameter bit FWD      = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flag_issue,
  input  logic                            flags_valid,
  input  logic [3:0]                      alu_flags,
  input  logic                            cond_req,
  input  logic [3:0]                      cond,
  output logic                            stall,
  output logic                            cond_valid,
  output logic                            cond_pass,
  output logic [3:0]                      nzcv,
  output logic [$clog2(MAX_PEND+1)-1:0]   pend_cnt,
  output logic                            proto_err
);

  localparam int             PW       = $clog2(MAX_PEND + 1);
  localparam logic [PW-1:0]  PEND_MAX = PW'(MAX_PEND);

  logic          at_zero, at_max;
  logic          retire, issue_ok;
  logic [PW-1:0] pend_eff;
  nzcv_t         eff_flags;
  logic          uncond, accept, eval_pass;

  assign at_zero  = (pend_cnt == '0);
  assign at_max   = (pend_cnt == PEND_MAX);
  assign retire   = flags_valid && !at_zero;
  // A retiring writeback frees a slot, so an issue at the limit is legal in that cycle.
  assign issue_ok = flag_issue && (!at_max || retire);

  // Same-cycle issue is younger than any request this cycle, so only the retire is counted.
  assign pend_eff  = pend_cnt - PW'(retire);
  assign eff_flags = (FWD && flags_valid) ? alu_flags : nzcv;
  assign uncond    = (cond_e'(cond) == AL) || (cond_e'(cond) == NV);
  assign stall     = cond_req && !uncond && ((pend_eff != '0) || (!FWD && flags_valid));
  assign accept    = cond_req && !stall;

  cond_eval u_eval (
    .cond  (cond),
    .flags (eff_flags),
    .pass  (eval_pass)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzcv       <= '0;
      pend_cnt   <= '0;
      proto_err  <= 1'b0;
      cond_valid <= 1'b0;
      cond_pass  <= 1'b0;
    end else begin
      if (flags_valid)
        nzcv <= alu_flags;
      case ({issue_ok, retire})
        2'b10:   pend_cnt <= pend_cnt + PW'(1);
        2'b01:   pend_cnt <= pend_cnt - PW'(1);
        default: pend_cnt <= pend_cnt;
      endcase
      if ((flags_valid && at_zero) || (flag_issue && at_max && !retire))
        proto_err <= 1'b1;
      cond_valid <= accept;
      if (accept)
        cond_pass <= eval_pass;
    end
  end

endmodule
